// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/freeze sequencer for the 5-stage RV32I pipeline
// Optional perf counters (stall_cnt_o, flush_cnt_o) are enabled with `define HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 255,
   parameter int REG_AW       = 5
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_branch_taken,
   input  logic              mem_req,
   input  logic              dmem_ready,
   output logic              stall_o,
   output logic              pc_hold_o,
   output logic              flush_if_id_o,
   output logic              bubble_id_ex_o,
   output logic              freeze_all_o,
   output logic              mem_timeout_o,
   output logic [1:0]        state_o
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt_o,
   output logic [31:0]       flush_cnt_o
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2,
      UNUSED   = 2'd3
   } state_t;

   localparam logic [1:0] FLUSH_LOAD  = 2'(FLUSH_CYCLES - 1);
   localparam logic [9:0] TIMEOUT_LIM = 10'(MEM_TIMEOUT);

   state_t     state_q, state_d, ret_q, ret_d, eff;
   logic [1:0] fcnt_q, fcnt_d;
   logic [9:0] wcnt_q, wcnt_d;
   logic       timeout_q, timeout_d;
   logic       freeze, load_use;
   logic       stall, pc_hold, flush, bubble, frz;

   assign freeze   = mem_req & ~dmem_ready;
   assign load_use = ex_mem_read & (ex_rd != '0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

   // MEM_WAIT behaves like the state it interrupted once the freeze lifts
   always_comb begin
      case (state_q)
         MEM_WAIT: eff = ret_q;
         FLUSH:    eff = FLUSH;
         default:  eff = RUN;
      endcase
   end

   always_comb begin
      state_d   = RUN;
      ret_d     = ret_q;
      fcnt_d    = fcnt_q;
      wcnt_d    = '0;
      timeout_d = timeout_q;
      stall     = 1'b0;
      pc_hold   = 1'b0;
      flush     = 1'b0;
      bubble    = 1'b0;
      frz       = 1'b0;
      if (freeze) begin
         frz     = 1'b1;
         stall   = 1'b1;
         pc_hold = 1'b1;
         state_d = MEM_WAIT;
         ret_d   = eff;
         wcnt_d  = (wcnt_q == TIMEOUT_LIM) ? wcnt_q : wcnt_q + 10'd1;
         if (wcnt_d == TIMEOUT_LIM)
            timeout_d = 1'b1;
      end else if (ex_branch_taken) begin
         flush  = 1'b1;
         bubble = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_LOAD;
         end
      end else if (eff == FLUSH) begin
         flush  = 1'b1;
         bubble = 1'b1;
         if (fcnt_q <= 2'd1) begin
            fcnt_d = '0;
         end else begin
            state_d = FLUSH;
            fcnt_d  = fcnt_q - 2'd1;
         end
      end else if (load_use) begin
         stall   = 1'b1;
         pc_hold = 1'b1;
         bubble  = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         ret_q     <= RUN;
         fcnt_q    <= '0;
         wcnt_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ret_q     <= ret_d;
         fcnt_q    <= fcnt_d;
         wcnt_q    <= wcnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign stall_o        = stall & rst_n;
   assign pc_hold_o      = pc_hold & rst_n;
   assign flush_if_id_o  = flush & rst_n;
   assign bubble_id_ex_o = bubble & rst_n;
   assign freeze_all_o   = frz & rst_n;
   assign mem_timeout_o  = timeout_q;
   assign state_o        = state_q;

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         stall_cnt_o <= stall_cnt_o + {31'd0, stall_o};
         flush_cnt_o <= flush_cnt_o + {31'd0, flush_if_id_o};
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - randomized + directed check of pipeline_hazard_ctrl against a cycle model
module tb_pipeline_hazard_ctrl;

   logic       CLK = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_req, dmem_ready;

   logic       stall[2], pc_hold[2], flush[2], bubble[2], frz[2], tmo[2];
   logic [1:0] st[2];
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] scnt[2], fcnt[2];
`endif

   int vectors = 0;
   int miscompares = 0;

   localparam int MT = 8;
   int fc[2] = '{2, 3};

   // model: remaining flush cycles, consecutive freeze cycles, sticky timeout, frozen last cycle
   int flush_left[2], wait_run[2], n_flush_left[2], n_wait_run[2];
   bit sticky[2], prev_freeze[2], n_sticky[2], n_prev_freeze[2];
`ifdef HAZ_PERF_CNT_EN
   int m_scnt[2], m_fcnt[2], n_scnt[2], n_fcnt[2];
`endif

   always #5 CLK = ~CLK;

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(MT), .REG_AW(5)) ua (
      .CLK(CLK), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .dmem_ready(dmem_ready),
      .stall_o(stall[0]), .pc_hold_o(pc_hold[0]), .flush_if_id_o(flush[0]),
      .bubble_id_ex_o(bubble[0]), .freeze_all_o(frz[0]), .mem_timeout_o(tmo[0]),
      .state_o(st[0])
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt_o(scnt[0]), .flush_cnt_o(fcnt[0])
`endif
   );

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(MT), .REG_AW(5)) ub (
      .CLK(CLK), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .dmem_ready(dmem_ready),
      .stall_o(stall[1]), .pc_hold_o(pc_hold[1]), .flush_if_id_o(flush[1]),
      .bubble_id_ex_o(bubble[1]), .freeze_all_o(frz[1]), .mem_timeout_o(tmo[1]),
      .state_o(st[1])
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt_o(scnt[1]), .flush_cnt_o(fcnt[1])
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int rs1, input int rs2, input bit u1, input bit u2, input int rd,
                        input bit mr, input bit bt, input bit mq, input bit rdy);
      id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2; ex_rd = 5'(rd);
      ex_mem_read = mr; ex_branch_taken = bt; mem_req = mq; dmem_ready = rdy;
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         bit e_frz, e_st, e_ph, e_fl, e_bub, fz, lu;
         int e_state;
         e_frz = 0; e_st = 0; e_ph = 0; e_fl = 0; e_bub = 0; e_state = 0;
         if (!rst_n) begin
            flush_left[i] = 0; wait_run[i] = 0; sticky[i] = 0; prev_freeze[i] = 0;
`ifdef HAZ_PERF_CNT_EN
            m_scnt[i] = 0; m_fcnt[i] = 0;
`endif
         end
         fz = mem_req && !dmem_ready;
         lu = ex_mem_read && ex_rd != 0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
         n_flush_left[i] = flush_left[i];
         n_wait_run[i] = 0;
         n_sticky[i] = sticky[i];
         n_prev_freeze[i] = fz;
         if (rst_n) begin
            e_state = prev_freeze[i] ? 2 : (flush_left[i] > 0 ? 1 : 0);
            if (fz) begin
               e_frz = 1; e_st = 1; e_ph = 1;
               n_wait_run[i] = wait_run[i] + 1;
               if (n_wait_run[i] >= MT) n_sticky[i] = 1;
            end else if (ex_branch_taken) begin
               e_fl = 1; e_bub = 1; n_flush_left[i] = fc[i] - 1;
            end else if (flush_left[i] > 0) begin
               e_fl = 1; e_bub = 1; n_flush_left[i] = flush_left[i] - 1;
            end else if (lu) begin
               e_st = 1; e_ph = 1; e_bub = 1;
            end
         end
         check($sformatf("outputs[%0d] {frz,stall,hold,flush,bub,tmo,state}", i),
               {25'd0, frz[i], stall[i], pc_hold[i], flush[i], bubble[i], tmo[i], st[i]},
               {25'd0, e_frz, e_st, e_ph, e_fl, e_bub, sticky[i], 2'(e_state)});
`ifdef HAZ_PERF_CNT_EN
         check($sformatf("stall_cnt[%0d]", i), scnt[i], 32'(m_scnt[i]));
         check($sformatf("flush_cnt[%0d]", i), fcnt[i], 32'(m_fcnt[i]));
         n_scnt[i] = m_scnt[i] + int'(e_st);
         n_fcnt[i] = m_fcnt[i] + int'(e_fl);
`endif
      end
   endtask

   task automatic cycle();
      #1;
      compare_all();
      @(posedge CLK);
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            flush_left[i] = n_flush_left[i]; wait_run[i] = n_wait_run[i];
            sticky[i] = n_sticky[i]; prev_freeze[i] = n_prev_freeze[i];
`ifdef HAZ_PERF_CNT_EN
            m_scnt[i] = n_scnt[i]; m_fcnt[i] = n_fcnt[i];
`endif
         end
      end
      @(negedge CLK);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      #1;
      check("reset state_o", 32'(st[0]), 32'd0);
      check("reset stall_o", 32'(stall[0]), 32'd0);
      cycle();
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      cycle();

      // load-use, then cleared, then rd=0
      drive(5, 0, 1, 0, 5, 1, 0, 0, 1); #1;
      check("load-use stall", {29'd0, stall[0], pc_hold[0], bubble[0]}, 32'd7);
      cycle();
      drive(5, 0, 1, 0, 5, 0, 0, 0, 1); #1;
      check("load-use cleared", {29'd0, stall[0], pc_hold[0], bubble[0]}, 32'd0);
      cycle();
      drive(0, 0, 1, 0, 0, 1, 0, 0, 1); #1;
      check("load-use rd0", 32'(stall[0]), 32'd0);
      cycle();

      // redirect, FLUSH_CYCLES=2
      drive(0, 0, 0, 0, 0, 0, 1, 0, 1); #1;
      check("redir c0 {flush,hold,state}", {28'd0, flush[0], pc_hold[0], st[0]}, 32'h8);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
      check("redir c1 {flush,hold,state}", {28'd0, flush[0], pc_hold[0], st[0]}, 32'h9);
      cycle();
      #1;
      check("redir c2 {flush,hold,state}", {28'd0, flush[0], pc_hold[0], st[0]}, 32'h0);
      cycle();

      // redirect + load-use together
      drive(7, 0, 1, 0, 7, 1, 1, 0, 1); #1;
      check("redir+lu {flush,stall,bub}", {29'd0, flush[0], stall[0], bubble[0]}, 32'd5);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) cycle();

      // memory wait with a pending branch
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 1, 0); #1;
         check("memwait {frz,flush}", {30'd0, frz[0], flush[0]}, 32'd2);
         cycle();
      end
      drive(0, 0, 0, 0, 0, 0, 1, 1, 1); #1;
      check("memwait done {frz,flush}", {30'd0, frz[0], flush[0]}, 32'd1);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) cycle();

      // timeout after 8 wait cycles
      for (int k = 0; k < 10; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
         if (k == 7) check("timeout before 8th", 32'(tmo[0]), 32'd0);
         if (k == 8) check("timeout after 8th", 32'(tmo[0]), 32'd1);
         cycle();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1); #1;
      check("timeout sticky", 32'(tmo[0]), 32'd1);
      cycle();

      // reset mid-FLUSH on the FLUSH_CYCLES=3 instance
      drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
      check("mid-flush state_o", 32'(st[1]), 32'd1);
      cycle();
      rst_n = 1'b0; #1;
      check("reset mid-flush {flush,state}", {29'd0, flush[1], st[1]}, 32'd0);
      check("reset clears timeout", 32'(tmo[0]), 32'd0);
      cycle();
      rst_n = 1'b1;
      cycle();

      // randomized phase
      for (int blk = 0; blk < 15; blk++) begin
         int rdy_pct;
         rdy_pct = (blk % 3 == 2) ? 15 : 70;
         for (int k = 0; k < 200; k++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 99) < 40,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < rdy_pct);
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
